// File: rtl/prom_spi_lb.sv
// Register-mapped SPI mode-0 master for the boot PROM: 1-4 byte transfers, software-managed CS.
// Reads return one cycle after the strobe; writes never stall, and CTRL/DATA writes are dropped while a transfer is busy.
module prom_spi_lb #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk_lb,
  input  logic        reset,
  input  logic        prom_wr,
  input  logic        prom_rd,
  input  logic [31:0] prom_addr,
  input  logic [31:0] prom_wr_d,
  output logic [31:0] prom_rd_d,
  output logic        prom_rd_rdy,
  output logic        spi_cs_l,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_DATA   = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [7:0] HP_RELOAD = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI} state_t;

  state_t      r_state;
  logic        r_cs_en;
  logic [1:0]  r_nbytes_m1;
  logic [31:0] r_tx_sr;
  logic [31:0] r_rx_sr;
  logic [5:0]  r_bit_cnt;
  logic [7:0]  r_hp_cnt;

  logic [1:0]  w_sel;
  logic        w_busy;
  logic        w_wr_ctrl;
  logic        w_wr_data;
  logic [2:0]  w_nbytes;
  logic        w_addr_unused;

  assign w_sel         = prom_addr[3:2];
  assign w_busy        = (r_state != IDLE);
  assign w_wr_ctrl     = prom_wr && (w_sel == A_CTRL) && !w_busy;
  assign w_wr_data     = prom_wr && (w_sel == A_DATA) && !w_busy;
  assign w_nbytes      = {1'b0, r_nbytes_m1} + 3'd1;
  assign w_addr_unused = ^{prom_addr[31:4], prom_addr[1:0]};
  // MOSI is the head of the shift register, so it only moves when tx_sr is loaded or shifted.
  assign spi_mosi      = r_tx_sr[31];

  always_ff @(posedge clk_lb) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cs_en     <= 1'b0;
      r_nbytes_m1 <= 2'd0;
      r_tx_sr     <= 32'd0;
      r_rx_sr     <= 32'd0;
      r_bit_cnt   <= 6'd0;
      r_hp_cnt    <= 8'd0;
      spi_cs_l    <= 1'b1;
      spi_sck     <= 1'b0;
      prom_rd_d   <= 32'd0;
      prom_rd_rdy <= 1'b0;
    end else begin
      // Read mux samples pre-write state, so a colliding write is not visible in this read.
      prom_rd_rdy <= prom_rd;
      if (prom_rd) begin
        case (w_sel)
          A_CTRL:   prom_rd_d <= {26'd0, r_nbytes_m1, 3'd0, r_cs_en};
          A_DATA:   prom_rd_d <= r_rx_sr;
          A_STATUS: prom_rd_d <= {31'd0, w_busy};
          default:  prom_rd_d <= 32'd0;
        endcase
      end

      if (w_wr_ctrl) begin
        r_cs_en     <= prom_wr_d[0];
        r_nbytes_m1 <= prom_wr_d[5:4];
        spi_cs_l    <= ~prom_wr_d[0];
      end

      case (r_state)
        IDLE: begin
          spi_sck <= 1'b0;
          if (w_wr_data) begin
            r_tx_sr   <= prom_wr_d;
            r_rx_sr   <= 32'd0;
            r_bit_cnt <= {w_nbytes, 3'b000};
            r_hp_cnt  <= HP_RELOAD;
            r_state   <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (r_hp_cnt == 8'd0) begin
            spi_sck  <= 1'b1;
            r_rx_sr  <= {r_rx_sr[30:0], spi_miso};
            r_hp_cnt <= HP_RELOAD;
            r_state  <= SHIFT_HI;
          end else begin
            r_hp_cnt <= r_hp_cnt - 8'd1;
          end
        end
        SHIFT_HI: begin
          if (r_hp_cnt == 8'd0) begin
            spi_sck   <= 1'b0;
            r_tx_sr   <= {r_tx_sr[30:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - 6'd1;
            r_hp_cnt  <= HP_RELOAD;
            r_state   <= (r_bit_cnt == 6'd1) ? IDLE : SHIFT_LO;
          end else begin
            r_hp_cnt <= r_hp_cnt - 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prom_spi_lb.sv
// Bench for prom_spi_lb: two instances (CLK_DIV=2 and CLK_DIV=1) sharing a bus, selected by sel.
// A flash model shifts a response word out on MISO; a monitor collects MOSI bits on rising SCK.
module tb_prom_spi_lb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr = 1'b0, rd = 1'b0, sel = 1'b0, loop = 1'b0;
  logic [31:0] addr = 32'd0, wr_d = 32'd0, resp = 32'd0;

  logic [31:0] rd_d_a, rd_d_b;
  logic        rdy_a, rdy_b, cs_a, cs_b, sck_a, sck_b, mosi_a, mosi_b;
  logic        miso_a, miso_b, flash_bit;

  logic [31:0] rd_d;
  logic        rd_rdy, cs_l, sck, mosi;

  int tests_run = 0, fails = 0;
  int cyc = 0, rise_cnt = 0, fall_cnt = 0, period_err = 0, mosi_err = 0, last_rise = 0;
  logic [31:0] mosi_acc = 32'd0;
  logic prev_sck = 1'b0, prev_mosi = 1'b0;

  always #5 clk = ~clk;

  prom_spi_lb #(.CLK_DIV(2)) dut_a (
    .clk_lb(clk), .reset(reset), .prom_wr(wr & ~sel), .prom_rd(rd & ~sel),
    .prom_addr(addr), .prom_wr_d(wr_d), .prom_rd_d(rd_d_a), .prom_rd_rdy(rdy_a),
    .spi_cs_l(cs_a), .spi_sck(sck_a), .spi_mosi(mosi_a), .spi_miso(miso_a)
  );

  prom_spi_lb #(.CLK_DIV(1)) dut_b (
    .clk_lb(clk), .reset(reset), .prom_wr(wr & sel), .prom_rd(rd & sel),
    .prom_addr(addr), .prom_wr_d(wr_d), .prom_rd_d(rd_d_b), .prom_rd_rdy(rdy_b),
    .spi_cs_l(cs_b), .spi_sck(sck_b), .spi_mosi(mosi_b), .spi_miso(miso_b)
  );

  assign rd_d      = sel ? rd_d_b : rd_d_a;
  assign rd_rdy    = sel ? rdy_b  : rdy_a;
  assign cs_l      = sel ? cs_b   : cs_a;
  assign sck       = sel ? sck_b  : sck_a;
  assign mosi      = sel ? mosi_b : mosi_a;
  assign flash_bit = (fall_cnt < 32) ? resp[5'(31 - fall_cnt)] : 1'b0;
  assign miso_a    = sel ? 1'b0 : (loop ? mosi_a : flash_bit);
  assign miso_b    = sel ? (loop ? mosi_b : flash_bit) : 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // SCK/MOSI monitor on the inactive edge
  always @(negedge clk) begin
    if (sck && !prev_sck) begin
      rise_cnt = rise_cnt + 1;
      mosi_acc = {mosi_acc[30:0], mosi};
      if (rise_cnt > 1 && (cyc - last_rise) != (sel ? 2 : 4)) period_err = period_err + 1;
      last_rise = cyc;
    end
    if (!sck && prev_sck) fall_cnt = fall_cnt + 1;
    if (mosi !== prev_mosi && sck) mosi_err = mosi_err + 1;
    prev_sck  = sck;
    prev_mosi = mosi;
  end

  task automatic clear_mon();
    rise_cnt = 0; fall_cnt = 0; period_err = 0; mosi_err = 0; mosi_acc = 32'd0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wr_d = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic r);
    addr = a; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    d = rd_d; r = rd_rdy;
  endtask

  // Polls STATUS every cycle; n = number of busy reads, misses = reads without rdy
  task automatic measure_busy(output int n, output int misses, output bit timeout);
    logic [31:0] d; logic r; bit done;
    n = 0; misses = 0; done = 0; timeout = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      bus_rd(32'h8, d, r);
      if (!r) misses++;
      if (d[0]) n++; else done = 1;
    end
    if (!done) timeout = 1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic r;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      tests_run++;
      if ({cs_l, sck, mosi, rd_rdy} !== 4'b1000 || rd_d !== 32'd0) begin
        fails++; $display("FAIL reset_outputs sel=%0d: cs/sck/mosi/rdy=%b%b%b%b rd_d=%h, want 1000 and 0", s, cs_l, sck, mosi, rd_rdy, rd_d);
      end
    end
    reset = 1'b0; sel = 1'b0;
    bus_rd(32'h8, d, r);
    tests_run++;
    if (d !== 32'd0 || r !== 1'b1) begin fails++; $display("FAIL reset_status: got %h rdy %b, want 0 rdy 1", d, r); end
    bus_rd(32'h0, d, r);
    tests_run++;
    if (d !== 32'd0) begin fails++; $display("FAIL reset_ctrl: got %h, want 0", d); end
  endtask

  task automatic test_single_loopback();
    logic [31:0] d; logic r; int n, m; bit to;
    sel = 1'b0; loop = 1'b1;
    bus_wr(32'h0, 32'h1);
    tests_run++;
    if (cs_l !== 1'b0) begin fails++; $display("FAIL cs_assert: got %b, want 0", cs_l); end
    clear_mon();
    bus_wr(32'h4, 32'hA500_0000);
    tests_run++;
    if (sck !== 1'b0 || mosi !== 1'b1) begin fails++; $display("FAIL first_bit: sck %b mosi %b, want 0 1", sck, mosi); end
    measure_busy(n, m, to);
    tests_run++;
    if (n != 32 || m != 0 || to) begin fails++; $display("FAIL single_busy: %0d cycles %0d rdy misses, want 32 0", n, m); end
    tests_run++;
    if (rise_cnt != 8 || period_err != 0 || mosi_err != 0 || mosi_acc !== 32'hA5) begin
      fails++; $display("FAIL single_wave: rises %0d perr %0d merr %0d mosi %h, want 8 0 0 a5", rise_cnt, period_err, mosi_err, mosi_acc);
    end
    bus_rd(32'h4, d, r);
    tests_run++;
    if (d !== 32'h0000_00A5) begin fails++; $display("FAIL single_rx: got %h, want 000000a5", d); end
  endtask

  task automatic test_four_bytes();
    logic [31:0] d; logic r; int n, m; bit to;
    sel = 1'b1; loop = 1'b0; resp = 32'hEF40_1800;
    bus_wr(32'h0, 32'h31);
    clear_mon();
    bus_wr(32'h4, 32'h9F12_3456);
    measure_busy(n, m, to);
    tests_run++;
    if (n != 64 || to) begin fails++; $display("FAIL four_busy: %0d cycles, want 64", n); end
    tests_run++;
    if (mosi_acc !== 32'h9F12_3456 || rise_cnt != 32 || period_err != 0) begin
      fails++; $display("FAIL four_mosi: got %h rises %0d perr %0d, want 9f123456 32 0", mosi_acc, rise_cnt, period_err);
    end
    bus_rd(32'h4, d, r);
    tests_run++;
    if (d !== 32'hEF40_1800) begin fails++; $display("FAIL four_rx: got %h, want ef401800", d); end
  endtask

  task automatic test_writes_while_busy();
    logic [31:0] d, x; logic r; int n, m; bit to;
    sel = 1'b0; loop = 1'b0; x = $urandom;
    bus_wr(32'h0, 32'h11);
    clear_mon();
    bus_wr(32'h4, x);
    repeat (5) @(posedge clk); #1;
    bus_wr(32'h4, 32'hFFFF_FFFF);
    bus_wr(32'h0, 32'h0);
    tests_run++;
    if (cs_l !== 1'b0) begin fails++; $display("FAIL busy_ctrl_cs: got %b, want 0", cs_l); end
    measure_busy(n, m, to);
    tests_run++;
    if (to || mosi_acc !== {16'd0, x[31:16]} || rise_cnt != 16) begin
      fails++; $display("FAIL busy_data_ignored: mosi %h rises %0d, want %h 16", mosi_acc, rise_cnt, {16'd0, x[31:16]});
    end
    bus_rd(32'h0, d, r);
    tests_run++;
    if (d !== 32'h11 || cs_l !== 1'b0) begin fails++; $display("FAIL busy_ctrl_kept: ctrl %h cs %b, want 11 0", d, cs_l); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, x; logic r; int n, m; bit to, hit;
    sel = 1'b0; loop = 1'b0; resp = $urandom;
    bus_wr(32'h0, 32'h11);
    clear_mon();
    bus_wr(32'h4, $urandom);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk); #1;
      if (rise_cnt >= 4) hit = 1;
    end
    tests_run++;
    if (!hit) begin fails++; $display("FAIL mid_wait: bit 3 never reached, rises %0d want 4", rise_cnt); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests_run++;
    if (cs_l !== 1'b1 || sck !== 1'b0) begin fails++; $display("FAIL mid_reset_pins: cs %b sck %b, want 1 0", cs_l, sck); end
    bus_rd(32'h8, d, r);
    tests_run++;
    if (d !== 32'd0) begin fails++; $display("FAIL mid_reset_busy: got %h, want 0", d); end
    loop = 1'b1; x = $urandom;
    bus_wr(32'h0, 32'h1);
    clear_mon();
    bus_wr(32'h4, x);
    measure_busy(n, m, to);
    bus_rd(32'h4, d, r);
    tests_run++;
    if (to || n != 32 || d !== {24'd0, x[31:24]}) begin
      fails++; $display("FAIL post_reset_xfer: busy %0d rx %h, want 32 %h", n, d, {24'd0, x[31:24]});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, a, b, c; logic r; int n, m; bit to;
    sel = 1'b1; loop = 1'b1; a = $urandom; b = $urandom; c = $urandom;
    bus_wr(32'h0, 32'h1);
    clear_mon();
    bus_wr(32'h4, a);                 // accepted at edge T
    repeat (15) @(posedge clk); #1;
    bus_wr(32'h4, b);                 // edge T+16: transfer still busy, dropped
    bus_wr(32'h4, c);                 // edge T+17: busy already reads 0, accepted
    measure_busy(n, m, to);
    tests_run++;
    if (to || mosi_acc !== {16'd0, a[31:24], c[31:24]} || rise_cnt != 16) begin
      fails++; $display("FAIL b2b_accept: mosi %h rises %0d, want %h 16", mosi_acc, rise_cnt, {16'd0, a[31:24], c[31:24]});
    end
    bus_rd(32'h4, d, r);
    tests_run++;
    if (d !== {24'd0, c[31:24]}) begin fails++; $display("FAIL b2b_rx: got %h, want %h", d, {24'd0, c[31:24]}); end
  endtask

  task automatic test_random();
    logic [31:0] d, x, exp_rx, exp_tx; logic r; int n, m, nb, div; bit to;
    loop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sel = 1'($urandom_range(0, 1)); div = sel ? 1 : 2;
      nb = $urandom_range(1, 4); x = $urandom; resp = $urandom;
      exp_rx = resp >> (32 - 8 * nb);
      exp_tx = x >> (32 - 8 * nb);
      bus_wr(32'h0, 32'((nb - 1) << 4) | 32'h1);
      clear_mon();
      bus_wr(32'h4, x);
      measure_busy(n, m, to);
      bus_rd(32'h4, d, r);
      tests_run++;
      if (to || n != 16 * nb * div || d !== exp_rx || mosi_acc !== exp_tx || period_err != 0 || mosi_err != 0) begin
        fails++; $display("FAIL random_%0d: n=%0d busy %0d rx %h mosi %h perr %0d merr %0d, want busy %0d rx %h mosi %h", i, nb, n, d, mosi_acc, period_err, mosi_err, 16 * nb * div, exp_rx, exp_tx);
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic r;
    sel = 1'b0;
    bus_wr(32'hFFFF_FFFC, 32'hFFFF_FFFF);
    bus_rd(32'hFFFF_FFFC, d, r);
    tests_run++;
    if (d !== 32'd0 || r !== 1'b1) begin fails++; $display("FAIL reserved_rd: got %h rdy %b, want 0 1", d, r); end
    @(posedge clk); #1;
    tests_run++;
    if (rd_rdy !== 1'b0 || rd_d !== 32'd0) begin fails++; $display("FAIL rdy_pulse: rdy %b d %h, want 0 0", rd_rdy, rd_d); end
    bus_wr(32'h0, 32'h1);
    addr = 32'h0; wr_d = 32'h21; wr = 1'b1; rd = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
    tests_run++;
    if (rd_d !== 32'h1 || rd_rdy !== 1'b1) begin fails++; $display("FAIL collide_old: got %h rdy %b, want 1 1", rd_d, rd_rdy); end
    bus_rd(32'h0, d, r);
    tests_run++;
    if (d !== 32'h21) begin fails++; $display("FAIL collide_new: got %h, want 21", d); end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_loopback();
    test_four_bytes();
    test_writes_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_collision();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
